// File: rtl/nx_node_instr_store.sv
// nx_node_instr_store: per-node instruction memory. Appends instructions from
// the load path and serves registered core fetches through one shared port.
// A load write and a fetch read never share a cycle; a fairness flag makes
// them alternate under sustained contention so neither side starves.
module nx_node_instr_store #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              load_valid_i,
  input  logic [DATA_W-1:0] load_data_i,
  output logic              load_ready_o,
  output logic [ADDR_W-1:0] populated_o,
  output logic              full_o,
  input  logic [ADDR_W-1:0] instr_addr_i,
  input  logic              instr_rd_i,
  output logic [DATA_W-1:0] instr_data_o,
  output logic              instr_stall_o
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_populated;
  logic              r_owed;
  logic [DATA_W-1:0] r_data;

  logic w_full;
  logic w_ready;
  logic w_acc;
  logic w_stall;
  logic w_fire;

  // Port arbitration: a pending fetch that was stalled last time wins the port.
  assign w_full  = (r_populated == ADDR_W'(DEPTH - 1));
  assign w_ready = !w_full && !clear_i && !(instr_rd_i && r_owed);
  assign w_acc   = load_valid_i && w_ready;
  assign w_stall = instr_rd_i && w_acc;
  assign w_fire  = instr_rd_i && !w_stall;

  // Append accepted loads; writes are suppressed while reset is held.
  always_ff @(posedge clk_i) begin
    if (rst_i && w_acc) r_mem[r_populated] <= load_data_i;
  end

  // Fill count, fairness flag and registered fetch data.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_populated <= '0;
      r_owed      <= 1'b0;
      r_data      <= '0;
    end else begin
      if (clear_i) begin
        r_populated <= '0;
        r_owed      <= 1'b0;
      end else begin
        if (w_acc) r_populated <= r_populated + 1'b1;
        if (instr_rd_i && w_acc) r_owed <= 1'b1;
        else if (w_fire)         r_owed <= 1'b0;
      end
      // Data holds across stalls so the core sees the last fetched word.
      if (w_fire) r_data <= r_mem[instr_addr_i];
    end
  end

  assign load_ready_o  = w_ready;
  assign instr_stall_o = w_stall;
  assign populated_o   = r_populated;
  assign full_o        = w_full;
  assign instr_data_o  = r_data;

endmodule

// File: doc/nx_node_instr_store.md
# nx_node_instr_store

Instruction store and fetch responder for a single node. It owns the node's instruction memory, appends instructions arriving from the node's load path, and answers the core's instruction fetches. Both share one memory port: a load write and a core fetch cannot happen in the same cycle, so the store raises a fetch stall whenever a write takes the port. It also publishes the populated-instruction count the core uses to bound execution.

## Interface
Parameters:
- DEPTH, MAX_NODE_INSTRS — memory rows; usable capacity is DEPTH-1 instructions.
- ADDR_W, $clog2(DEPTH) — address and count width; must equal the core's fetch-address width.

Ports:
- clk_i  input  1  — single clock.
- rst_i  input  1  — synchronous, active-low reset.
- clear_i  input  1  — one-cycle pulse; empties the store.
- load_valid_i  input  1  — load offer.
- load_data_i  input  instruction_t  — instruction to append.
- load_ready_o  output  1  — load accepted this cycle when high together with load_valid_i.
- populated_o  output  ADDR_W  — number of loaded instructions.
- full_o  output  1  — populated_o == DEPTH-1.
- instr_addr_i  input  ADDR_W  — fetch address.
- instr_rd_i  input  1  — fetch request.
- instr_data_o  output  instruction_t  — fetched instruction (registered).
- instr_stall_o  output  1  — fetch not performed this cycle.

## Operation
- Memory: DEPTH x instruction_t register array, single logical port. Contents are not reset.
- Load accept is combinational: `acc = load_valid_i && load_ready_o`.
  - Otherwise `load_ready_o = !full_q && !clear_i && !(instr_rd_i && owed_q)`.
  - On `acc`, write mem[populated_q] and increment populated_q.
- Fetch performed: `fire = instr_rd_i && !instr_stall_o`.
  - Otherwise `instr_stall_o = instr_rd_i && acc`.
  - On `fire`, instr_data_q <= mem[instr_addr_i]. Otherwise instr_data_q holds its value, so data survives any number of stall cycles.
- Fairness flag `owed_q`: set when a cycle has both `instr_rd_i` and `acc`. Cleared on any `fire`. Result: under continuous contention, loads and fetches alternate and neither starves.
- No contention: loads proceed at 1/cycle and fetches at 1/cycle.
- clear_i: populated_q <= 0 and owed_q <= 0. No load is accepted in that cycle. A fetch in that cycle is still served. Memory is untouched.
- Full: load_ready_o stays low and load_valid_i is ignored, i.e. back-pressure rather than drop. A populated_q wrap to 0 is therefore impossible.
- Fetch address is not range-checked. Addresses >= populated_o return stale memory; the core bounds fetch by populated_o.
- Reset (rst_i low at an edge) applies mid-operation too:
  - instr_data_o = 0, populated_o = 0, full_o = 0, owed_q = 0.
  - load_ready_o and instr_stall_o follow their equations.

## Timing
- Fetch latency is 1: `fire` in cycle N gives instr_data_o = mem[addr] from cycle N+1 until the next `fire`.
- A stalled cycle performs no read. The core holds its address and retries the next cycle; no request is queued.
- Load-to-visible:
  - A write accepted in cycle N is readable by a fetch fired in N+1.
  - populated_o and full_o update at the N+1 edge.
- Read-during-write to the same row cannot occur, because the port is exclusive.
- instr_stall_o and load_ready_o are combinational from load_valid_i, instr_rd_i, clear_i and registered state. Neither depends on instr_addr_i or load_data_i.

## Test plan
- Reset values: hold rst_i low 3 cycles with rd and valid high, then release. Required: populated_o=0, instr_data_o=0, full_o=0. No write occurs during reset.
- Load then fetch:
  - Load 4 instructions back-to-back with rd low. Required: load_ready_o high each cycle, populated_o steps 1..4.
  - Then fetch addresses 0..3 on consecutive cycles. Required: data equals the loaded words at 1-cycle latency, instr_stall_o never high.
- Contention fairness: rd and load_valid held high for 8 cycles. Required: stall pattern 1,0,1,0,…; 4 loads accepted, 4 fetches fired; instr_data_o unchanged across each stalled cycle.
- Full: DEPTH=8, offer 9 loads. Required: 7 accepted, full_o=1 and load_ready_o=0 thereafter, populated_o=7, mem[7] untouched.
- Clear concurrent with load and fetch: clear_i and load_valid_i high while rd fires on address 2. Required:
  - That cycle: load not accepted, fetch served with no stall.
  - Next cycle: populated_o=0, and a new load lands at address 0.
- Reset mid-contention: assert rst_i while owed_q=1 and populated_o=5. Required: after release populated_o=0, and the first contending cycle stalls the fetch (owed_q cleared).
